// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: PDM microphone clocking, warmup and frame capture.
// Optional stereo channel alternation is enabled by defining MIC_STEREO_EN.
module mic_capture_ctrl #(
   parameter int CLK_DIV    = 4,
   parameter int FRAME_BITS = 16,
   parameter int WARMUP_CYC = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  dataint,
   output logic                  mclk,
   output logic                  ws,
   output logic [FRAME_BITS-1:0] sample,
   output logic                  sample_ch,
   output logic                  sample_valid,
   input  logic                  sample_ready,
   output logic                  overrun,
   output logic                  busy
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
   localparam int BW = $clog2(FRAME_BITS);

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      WARMUP,
      CAPTURE
   } state_e;

   state_e                state_q, state_d;
   logic [DW-1:0]         div_q, div_d;
   logic                  mclk_q, mclk_d;
   logic [WW-1:0]         wcnt_q, wcnt_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic [FRAME_BITS-2:0] shift_q, shift_d;
   logic [FRAME_BITS-1:0] sample_q, sample_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;

   logic                  tog;
   logic                  fall;
   logic                  cap_bit;
   logic                  done;
   logic                  load;
   logic [FRAME_BITS-1:0] word;

   // The shift register holds the older bits; the live bit completes a word.
   assign word    = {shift_q, dataint};
   assign tog     = (state_q != IDLE) && (div_q == DIV_LAST);
   assign fall    = tog && mclk_q;
   assign cap_bit = (state_q == CAPTURE) && en && fall;
   assign done    = cap_bit && (bcnt_q == BIT_LAST);
   assign load    = done && (!valid_q || sample_ready);

   // State, divider, counters and capture datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         div_q    <= '0;
         mclk_q   <= 1'b0;
         wcnt_q   <= '0;
         bcnt_q   <= '0;
         shift_q  <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         mclk_q   <= mclk_d;
         wcnt_q   <= wcnt_d;
         bcnt_q   <= bcnt_d;
         shift_q  <= shift_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   // Next state, mclk divider, warmup period count and bit shifting.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      mclk_d  = mclk_q;
      wcnt_d  = wcnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            div_d   = '0;
            mclk_d  = 1'b0;
            wcnt_d  = '0;
            bcnt_d  = '0;
            shift_d = '0;
            if (en) begin
               state_d = (WARMUP_CYC == 0) ? CAPTURE : WARMUP;
            end
         end
         WARMUP, CAPTURE: begin
            if (!en) begin
               state_d = IDLE;
               div_d   = '0;
               mclk_d  = 1'b0;
               wcnt_d  = '0;
               bcnt_d  = '0;
               shift_d = '0;
            end else begin
               div_d  = tog ? '0 : div_q + DW'(1);
               mclk_d = mclk_q ^ tog;
               if ((state_q == WARMUP) && fall) begin
                  if (wcnt_q == WARM_LAST) begin
                     state_d = CAPTURE;
                     wcnt_d  = '0;
                     bcnt_d  = '0;
                  end else begin
                     wcnt_d = wcnt_q + WW'(1);
                  end
               end
               if (cap_bit) begin
                  shift_d = word[FRAME_BITS-2:0];
                  bcnt_d  = done ? '0 : bcnt_q + BW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output handshake: load when free or being drained, else drop.
   always_comb begin
      sample_d = sample_q;
      valid_d  = valid_q;
      ovr_d    = 1'b0;
      if (load) begin
         sample_d = word;
         valid_d  = 1'b1;
      end else begin
         if (valid_q && sample_ready) begin
            valid_d = 1'b0;
         end
         if (done) begin
            ovr_d = 1'b1;
         end
      end
   end

`ifdef MIC_STEREO_EN
   logic ws_q, ws_d;
   logic ch_q, ch_d;

   // Channel select and the channel tag of the held sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ws_q <= 1'b0;
         ch_q <= 1'b0;
      end else begin
         ws_q <= ws_d;
         ch_q <= ch_d;
      end
   end

   // ws flips on every completed frame, dropped or not; restarts on enable.
   always_comb begin
      ws_d = ws_q;
      ch_d = ch_q;
      if ((state_q == IDLE) && en) begin
         ws_d = 1'b0;
      end else if (done) begin
         ws_d = ~ws_q;
      end
      if (load) begin
         ch_d = ws_q;
      end
   end

   assign ws        = ws_q;
   assign sample_ch = ch_q;
`else
   assign ws        = 1'b0;
   assign sample_ch = 1'b0;
`endif

   assign mclk         = mclk_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// tb_mic_capture_ctrl: directed and random capture checks against a
// timing-arithmetic reference model of the microphone controller.
module tb_mic_capture_ctrl;

   localparam int CD = 2;
   localparam int FB = 8;
   localparam int W  = 4;
`ifdef MIC_STEREO_EN
   localparam bit STEREO = 1'b1;
`else
   localparam bit STEREO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          dataint;
   logic          mclk;
   logic          ws;
   logic [FB-1:0] sample;
   logic          sample_ch;
   logic          sample_valid;
   logic          sample_ready;
   logic          overrun;
   logic          busy;

   mic_capture_ctrl #(
      .CLK_DIV    (CD),
      .FRAME_BITS (FB),
      .WARMUP_CYC (W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .dataint      (dataint),
      .mclk         (mclk),
      .ws           (ws),
      .sample       (sample),
      .sample_ch    (sample_ch),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int nfail = 0;
   int nchk  = 0;

   // reference model: edges since enable, captured bits, handshake state
   bit          m_act;
   int          m_t;
   bit          m_bits[$];
   bit          m_valid;
   bit          m_ovr;
   bit          m_ws;
   bit          m_ch;
   bit          m_load;
   logic [FB-1:0] m_sample;
   int          ndone;
   int          nloads;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 0;
      m_t = 0;
      m_bits.delete();
      m_valid = 0;
      m_ovr = 0;
      m_ws = 0;
      m_ch = 0;
      m_load = 0;
      m_sample = '0;
   endtask

   // mclk rises CD edges after enable and toggles every CD edges after.
   function automatic bit exp_mclk();
      if (!m_act) return 1'b0;
      return 1'((m_t / CD) % 2);
   endfunction

   // Capture bit index sampled on the next edge, or -1.
   function automatic int cap_idx_next();
      int t;
      if (!m_act) return -1;
      t = m_t + 1;
      if (t % (2 * CD) != 0) return -1;
      if (t / (2 * CD) <= W) return -1;
      return t / (2 * CD) - W - 1;
   endfunction

   function automatic bit next_done();
      return (cap_idx_next() >= 0) && (m_bits.size() == FB - 1);
   endfunction

   task automatic model_edge(input bit e, input bit d, input bit r);
      bit done;
      logic [FB-1:0] w;
      done = 0;
      w = '0;
      m_ovr = 0;
      m_load = 0;
      if (!m_act) begin
         if (e) begin
            m_act = 1;
            m_t = 0;
            m_ws = 0;
            m_bits.delete();
         end
      end else if (!e) begin
         m_act = 0;
         m_bits.delete();
      end else begin
         m_t++;
         if ((m_t % (2 * CD) == 0) && (m_t / (2 * CD) > W)) begin
            m_bits.push_back(d);
            if (m_bits.size() == FB) begin
               done = 1;
               foreach (m_bits[i]) w = {w[FB-2:0], m_bits[i]};
               m_bits.delete();
            end
         end
      end
      if (done) begin
         ndone++;
         if (!m_valid || r) begin
            m_valid = 1;
            m_sample = w;
            m_ch = m_ws;
            m_load = 1;
            nloads++;
         end else begin
            m_ovr = 1;
         end
         m_ws = ~m_ws;
      end else if (m_valid && r) begin
         m_valid = 0;
      end
   endtask

   task automatic check_all();
      chk("mclk", mclk, exp_mclk());
      chk("busy", busy, m_act);
      chk("valid", sample_valid, m_valid);
      chk("sample", sample, m_sample);
      chk("overrun", overrun, m_ovr);
      chk("ws", ws, STEREO ? m_ws : 1'b0);
      chk("sample_ch", sample_ch, STEREO ? m_ch : 1'b0);
   endtask

   task automatic tick(input bit e, input bit d, input bit r);
      en = e;
      dataint = d;
      sample_ready = r;
      @(posedge clk);
      model_edge(e, d, r);
      #1;
      check_all();
   endtask

   logic [FB-1:0] pat;
   int  n, k, per, rise_prev, novr, d0, l0;
   bit  d, e, rdy, pm;
   bit  chq[$];

   initial begin
      reset = 1'b0;
      en = 1'b0;
      dataint = 1'b0;
      sample_ready = 1'b0;
      ndone = 0;
      nloads = 0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      #1 reset = 1'b1;

      // basic capture with a known pattern, mclk period measurement
      pat = 8'hB2;
      rise_prev = -1;
      per = -1;
      n = 0;
      while (sample_valid !== 1'b1 && n < 200) begin
         k = cap_idx_next();
         d = (k >= 0) ? pat[7 - (k % 8)] : 1'($urandom);
         pm = mclk;
         tick(1, d, 0);
         n++;
         if (!pm && mclk === 1'b1) begin
            if (rise_prev >= 0 && per < 0) per = n - rise_prev;
            rise_prev = n;
         end
      end
      chk("basic_valid", sample_valid, 1);
      chk("basic_sample", sample, 8'hB2);
      chk("basic_busy", busy, 1);
      chk("mclk_period", per, 4);

      // drain with enable low, then warmup data must be discarded
      tick(0, 0, 1);
      chk("drop_busy", busy, 0);
      chk("drop_accept", sample_valid, 0);
      tick(0, 0, 0);
      n = 0;
      while (sample_valid !== 1'b1 && n < 200) begin
         k = cap_idx_next();
         tick(1, (k >= 0) ? 1'b0 : 1'b1, 0);
         n++;
      end
      chk("warm_valid", sample_valid, 1);
      chk("warm_sample", sample, 8'h00);

      // second completion with ready low: dropped, single overrun pulse
      d0 = ndone;
      novr = 0;
      n = 0;
      while (ndone == d0 && n < 100) begin
         tick(1, 1'($urandom), 0);
         n++;
         if (overrun === 1'b1) novr++;
      end
      tick(1, 1'($urandom), 0);
      if (overrun === 1'b1) novr++;
      chk("ovr_pulses", novr, 1);
      chk("ovr_hold", sample, 8'h00);
      chk("ovr_valid", sample_valid, 1);

      // accept on the completion clk: reload without overrun
      n = 0;
      rdy = 0;
      while (!rdy && n < 100) begin
         rdy = next_done();
         k = cap_idx_next();
         tick(1, (k >= 0) ? 1'b1 : 1'($urandom), rdy);
         n++;
      end
      chk("simul_valid", sample_valid, 1);
      chk("simul_sample", sample, 8'hFF);
      chk("simul_ovr", overrun, 0);

      // enable drop after 3 bits with a pending sample
      n = 0;
      while (m_bits.size() != 3 && n < 100) begin
         tick(1, 1'($urandom), 0);
         n++;
      end
      tick(0, 1'($urandom), 0);
      chk("endrop_busy", busy, 0);
      chk("endrop_mclk", mclk, 0);
      chk("endrop_pend", sample_valid, 1);
      chk("endrop_hold", sample, 8'hFF);
      for (int i = 0; i < 3; i++) tick(0, 1'($urandom), 0);
      tick(0, 0, 1);
      chk("endrop_acc", sample_valid, 0);
      tick(0, 0, 0);
      chk("endrop_nonew", sample_valid, 0);
      n = 0;
      while (sample_valid !== 1'b1 && n < 200) begin
         k = cap_idx_next();
         d = (k >= 0) ? pat[7 - (k % 8)] : 1'($urandom);
         tick(1, d, 0);
         n++;
      end
      chk("reen_latency", n, 2 * CD * (W + FB) + 1);
      chk("reen_sample", sample, 8'hB2);

      // random traffic with bursty ready and occasional enable drops
      e = 1;
      rdy = 1;
      for (int i = 0; i < 900; i++) begin
         if (e && $urandom_range(0, 149) == 0) e = 0;
         else if (!e && $urandom_range(0, 5) == 0) e = 1;
         if ($urandom_range(0, 15) == 0) rdy = ~rdy;
         tick(e, 1'($urandom), rdy);
      end

      // asynchronous reset mid-frame
      n = 0;
      while (!(m_act && m_valid && m_bits.size() == 3) && n < 300) begin
         tick(1, 1'($urandom), 0);
         n++;
      end
      chk("pre_rst_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mclk", mclk, 0);
      chk("rst_ws", ws, 0);
      chk("rst_sample", sample, 0);
      chk("rst_ch", sample_ch, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      model_reset();
      #3 reset = 1'b1;

      // channel tags of four successive frames
      l0 = nloads;
      n = 0;
      while (nloads - l0 < 4 && n < 400) begin
         tick(1, 1'($urandom), 1);
         n++;
         if (m_load) chq.push_back(sample_ch);
      end
      chk("ch_count", chq.size(), 4);
      foreach (chq[i]) chk("ch_seq", chq[i], STEREO ? (i % 2) : 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
